// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin decoded-select arbiter.
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  localparam logic [IDX_W-1:0]   PTR_RST      = 3'd7;
  localparam logic [NUM_REQ-1:0] GRANT_N_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_next_index.sv
// Rotate-priority picker: first set REQ bit searching upward from PTR+1, wrapping mod 8.
module rr_next_index
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [IDX_W-1:0]   PTR,
  output logic [IDX_W-1:0]   IDX,
  output logic               FOUND
);

  logic [IDX_W-1:0] w_cand;

  // PTR itself is visited last, giving the previous grantee the lowest priority.
  always_comb begin
    IDX    = '0;
    FOUND  = 1'b0;
    w_cand = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = PTR + IDX_W'(i);
      if (!FOUND && REQ[w_cand]) begin
        IDX   = w_cand;
        FOUND = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter driving a 3-bit select and active-low one-hot grant with a dead cycle between owners.
// Optional hold-timeout enabled by defining RR_DECODE_ARBITER_TIMEOUT_EN.
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               EN,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               DONE,
  output logic [IDX_W-1:0]   SEL,
  output logic               GVALID,
  output logic [NUM_REQ-1:0] GRANT_N,
  output logic               TIMEOUT
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_decode_arbiter: MAX_HOLD must be within 2..255");
  end

  arb_state_t         r_state;
  arb_state_t         w_next_state;
  logic [IDX_W-1:0]   r_sel;
  logic [IDX_W-1:0]   r_ptr;
  logic               r_gvalid;
  logic [NUM_REQ-1:0] r_grant_n;
  logic               r_timeout;
  logic [IDX_W-1:0]   w_next_sel;
  logic [IDX_W-1:0]   w_next_ptr;
  logic               w_next_gvalid;
  logic [NUM_REQ-1:0] w_next_grant_n;
  logic               w_next_timeout;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic               w_expire;

  rr_next_index u_next_index (
    .REQ   (REQ),
    .PTR   (r_ptr),
    .IDX   (w_pick_idx),
    .FOUND (w_pick_found)
  );

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold;

  // Counts completed BUSY cycles; expiry fires at the end of the MAX_HOLD-th one.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                r_hold <= '0;
    else if (r_state != BUSY) r_hold <= '0;
    else                      r_hold <= r_hold + 8'd1;
  end

  assign w_expire = (r_state == BUSY) && (r_hold == HOLD_LAST);
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state plus next output values; every output leaves the block from a flop.
  always_comb begin
    w_next_state   = r_state;
    w_next_sel     = r_sel;
    w_next_ptr     = r_ptr;
    w_next_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (EN && w_pick_found) begin
          w_next_state = BUSY;
          w_next_sel   = w_pick_idx;
          w_next_ptr   = w_pick_idx;
        end
      end
      BUSY: begin
        if (DONE || !REQ[r_sel]) begin
          w_next_state = GAP;
        end else if (w_expire) begin
          w_next_state   = GAP;
          w_next_timeout = 1'b1;
        end
      end
      GAP:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    w_next_gvalid  = (w_next_state == BUSY);
    w_next_grant_n = w_next_gvalid ? ~(8'b1 << w_next_sel) : GRANT_N_IDLE;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sel     <= '0;
      r_ptr     <= PTR_RST;
      r_gvalid  <= 1'b0;
      r_grant_n <= GRANT_N_IDLE;
      r_timeout <= 1'b0;
    end else begin
      r_sel     <= w_next_sel;
      r_ptr     <= w_next_ptr;
      r_gvalid  <= w_next_gvalid;
      r_grant_n <= w_next_grant_n;
      r_timeout <= w_next_timeout;
    end
  end

  assign SEL     = r_sel;
  assign GVALID  = r_gvalid;
  assign GRANT_N = r_grant_n;
  assign TIMEOUT = r_timeout;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter and its rr_next_index picker.
module tb_rr_decode_arbiter;

  logic       CLK;
  logic       RSTN;
  logic       EN;
  logic [7:0] REQ;
  logic       DONE;
  logic [2:0] SEL;
  logic       GVALID;
  logic [7:0] GRANT_N;
  logic       TIMEOUT;

  logic [7:0] pickReq;
  logic [2:0] pickPtr;
  logic [2:0] pickIdx;
  logic       pickFound;

  int checkCount;
  int failCount;

  rr_decode_arbiter #(.MAX_HOLD(4)) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .EN      (EN),
    .REQ     (REQ),
    .DONE    (DONE),
    .SEL     (SEL),
    .GVALID  (GVALID),
    .GRANT_N (GRANT_N),
    .TIMEOUT (TIMEOUT)
  );

  rr_next_index picker (
    .REQ   (pickReq),
    .PTR   (pickPtr),
    .IDX   (pickIdx),
    .FOUND (pickFound)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_picker();
    logic [7:0] reqs [5]  = '{8'h00, 8'h81, 8'h81, 8'h10, 8'hFF};
    logic [2:0] ptrs [5]  = '{3'd3,  3'd7,  3'd0,  3'd4,  3'd2};
    logic [2:0] idxs [5]  = '{3'd0,  3'd0,  3'd7,  3'd4,  3'd3};
    logic       founds [5] = '{1'b0, 1'b1,  1'b1,  1'b1,  1'b1};
    for (int i = 0; i < 5; i++) begin
      pickReq = reqs[i];
      pickPtr = ptrs[i];
      #1;
      checkCount++;
      if (pickFound !== founds[i] || (founds[i] && pickIdx !== idxs[i])) begin
        failCount++;
        $display("[TB] FAIL picker[%0d] got found=%b idx=%0d want found=%b idx=%0d",
                 i, pickFound, pickIdx, founds[i], idxs[i]);
      end
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; EN = 1'b0; REQ = 8'hFF; DONE = 1'b0;
    tick(); tick();
    checkCount++;
    if (GRANT_N !== 8'hFF || GVALID !== 1'b0 || SEL !== 3'd0 || TIMEOUT !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_values got grant_n=%h gvalid=%b sel=%0d timeout=%b want FF 0 0 0",
               GRANT_N, GVALID, SEL, TIMEOUT);
    end
    RSTN = 1'b1; EN = 1'b1;
    tick();
    checkCount++;
    if (GRANT_N !== 8'hFE || GVALID !== 1'b1 || SEL !== 3'd0) begin
      failCount++;
      $display("[TB] FAIL first_grant got grant_n=%h gvalid=%b sel=%0d want FE 1 0",
               GRANT_N, GVALID, SEL);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] want;
    for (int k = 1; k <= 8; k++) begin
      want = 3'(k % 8);
      tick();
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      checkCount++;
      if (GRANT_N !== 8'hFF || GVALID !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL fair_gap[%0d] got grant_n=%h gvalid=%b want FF 0", k, GRANT_N, GVALID);
      end
      tick();
      tick();
      checkCount++;
      if (SEL !== want || GRANT_N !== ~(8'b1 << want) || GVALID !== 1'b1) begin
        failCount++;
        $display("[TB] FAIL fair_grant[%0d] got sel=%0d grant_n=%h want sel=%0d grant_n=%h",
                 k, SEL, GRANT_N, want, ~(8'b1 << want));
      end
    end
  endtask

  task automatic test_sparse();
    REQ = 8'h20; DONE = 1'b1;
    tick(); DONE = 1'b0; tick(); tick();
    checkCount++;
    if (SEL !== 3'd5 || GRANT_N !== 8'hDF) begin
      failCount++;
      $display("[TB] FAIL sparse_5 got sel=%0d grant_n=%h want 5 DF", SEL, GRANT_N);
    end
    REQ = 8'b1000_0100;
    tick(); tick(); tick();
    checkCount++;
    if (SEL !== 3'd7 || GRANT_N !== 8'h7F) begin
      failCount++;
      $display("[TB] FAIL sparse_7 got sel=%0d grant_n=%h want 7 7F", SEL, GRANT_N);
    end
    DONE = 1'b1;
    tick(); DONE = 1'b0; tick(); tick();
    checkCount++;
    if (SEL !== 3'd2 || GRANT_N !== 8'hFB) begin
      failCount++;
      $display("[TB] FAIL sparse_2 got sel=%0d grant_n=%h want 2 FB", SEL, GRANT_N);
    end
  endtask

  task automatic test_withdraw_enable();
    REQ = 8'h08; DONE = 1'b1;
    tick(); DONE = 1'b0; tick(); tick();
    checkCount++;
    if (SEL !== 3'd3 || GRANT_N !== 8'hF7) begin
      failCount++;
      $display("[TB] FAIL withdraw_setup got sel=%0d grant_n=%h want 3 F7", SEL, GRANT_N);
    end
    REQ = 8'h00;
    tick();
    checkCount++;
    if (GRANT_N !== 8'hFF || GVALID !== 1'b0 || SEL !== 3'd3) begin
      failCount++;
      $display("[TB] FAIL withdraw_gap got grant_n=%h gvalid=%b sel=%0d want FF 0 3",
               GRANT_N, GVALID, SEL);
    end
    REQ = 8'h10;
    tick(); tick();
    EN = 1'b0;
    tick(); tick();
    checkCount++;
    if (SEL !== 3'd4 || GRANT_N !== 8'hEF || GVALID !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL en_low_hold got sel=%0d grant_n=%h gvalid=%b want 4 EF 1",
               SEL, GRANT_N, GVALID);
    end
    DONE = 1'b1;
    tick(); DONE = 1'b0;
    tick(); tick(); tick(); tick();
    checkCount++;
    if (GRANT_N !== 8'hFF || GVALID !== 1'b0 || SEL !== 3'd4) begin
      failCount++;
      $display("[TB] FAIL en_low_nogrant got grant_n=%h gvalid=%b sel=%0d want FF 0 4",
               GRANT_N, GVALID, SEL);
    end
    EN = 1'b1;
    tick();
    checkCount++;
    if (SEL !== 3'd4 || GRANT_N !== 8'hEF) begin
      failCount++;
      $display("[TB] FAIL en_regrant got sel=%0d grant_n=%h want 4 EF", SEL, GRANT_N);
    end
  endtask

  task automatic test_async_reset();
    REQ = 8'h08; DONE = 1'b1;
    tick(); DONE = 1'b0; tick(); tick();
    checkCount++;
    if (GRANT_N !== 8'hF7) begin
      failCount++;
      $display("[TB] FAIL areset_setup got grant_n=%h want F7", GRANT_N);
    end
    #3;
    RSTN = 1'b0;
    #1;
    checkCount++;
    if (GRANT_N !== 8'hFF || GVALID !== 1'b0 || SEL !== 3'd0) begin
      failCount++;
      $display("[TB] FAIL areset_async got grant_n=%h gvalid=%b sel=%0d want FF 0 0",
               GRANT_N, GVALID, SEL);
    end
    REQ = 8'h0C;
    tick();
    RSTN = 1'b1;
    tick();
    checkCount++;
    if (SEL !== 3'd2 || GRANT_N !== 8'hFB) begin
      failCount++;
      $display("[TB] FAIL areset_ptr got sel=%0d grant_n=%h want 2 FB", SEL, GRANT_N);
    end
  endtask

  task automatic test_timeout();
    REQ = 8'h02;
    tick(); tick(); tick();
    checkCount++;
    if (SEL !== 3'd1 || GRANT_N !== 8'hFD || TIMEOUT !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL hold_setup got sel=%0d grant_n=%h timeout=%b want 1 FD 0",
               SEL, GRANT_N, TIMEOUT);
    end
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
    tick(); tick(); tick();
    checkCount++;
    if (GRANT_N !== 8'hFD || TIMEOUT !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL timeout_held got grant_n=%h timeout=%b want FD 0", GRANT_N, TIMEOUT);
    end
    tick();
    checkCount++;
    if (GRANT_N !== 8'hFF || GVALID !== 1'b0 || TIMEOUT !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL timeout_fire got grant_n=%h gvalid=%b timeout=%b want FF 0 1",
               GRANT_N, GVALID, TIMEOUT);
    end
    tick();
    checkCount++;
    if (GRANT_N !== 8'hFF || TIMEOUT !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL timeout_pulse got grant_n=%h timeout=%b want FF 0", GRANT_N, TIMEOUT);
    end
    tick();
    checkCount++;
    if (SEL !== 3'd1 || GRANT_N !== 8'hFD) begin
      failCount++;
      $display("[TB] FAIL timeout_regrant got sel=%0d grant_n=%h want 1 FD", SEL, GRANT_N);
    end
`else
    for (int c = 0; c < 100; c++) begin
      tick();
      checkCount++;
      if (GRANT_N !== 8'hFD || TIMEOUT !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL hold_persist[%0d] got grant_n=%h timeout=%b want FD 0",
                 c, GRANT_N, TIMEOUT);
      end
    end
`endif
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    RSTN = 1'b0; EN = 1'b0; REQ = 8'h00; DONE = 1'b0;
    pickReq = 8'h00; pickPtr = 3'd0;
    test_picker();
    test_reset();
    test_fairness();
    test_sparse();
    test_withdraw_enable();
    test_async_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
